// File: rtl/mem_cycle_ctrl.sv
// mem_cycle_ctrl
// Sequences one memory access per accepted request through
// IDLE -> SETUP -> START -> ACCESS -> END -> RECOVER -> IDLE.
// It drives a downstream address latch and the read/write strobes.
// Every output is a register, so no input reaches an output combinationally.
//
// Parameters:
//   ADDR_WIDTH - request / latch address width
//   MIN_WAIT   - minimum ACCESS cycles before mem_ready is honoured (1..254)
//   TIMEOUT    - ACCESS cycles after which the cycle aborts (MIN_WAIT+1..255)
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   req_valid/ready - request handshake, accepted only in IDLE
//   req_addr/write  - request address and direction (1 = write)
//   mem_ready       - memory reports the access is complete
//   latch_addr      - captured address presented to the address latch
//   addr_valid      - latch_addr valid (SETUP through END)
//   mem_cycle_start - one-cycle pulse in START
//   mem_cycle_end   - one-cycle pulse in END
//   mem_oe / mem_we - read / write strobes, ACCESS only
//   done            - one-cycle pulse in END on normal completion
//   timeout_err     - one-cycle pulse in END on timeout abort
//   xfer_count      - count of normally completed cycles (wraps at 255)
module mem_cycle_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int MIN_WAIT   = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] latch_addr,
  output logic                  addr_valid,
  output logic                  mem_cycle_start,
  output logic                  mem_cycle_end,
  output logic                  mem_oe,
  output logic                  mem_we,
  output logic                  done,
  output logic                  timeout_err,
  output logic [7:0]            xfer_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_START   = 3'd2,
    S_ACCESS  = 3'd3,
    S_END     = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  // The counter value seen on the last ACCESS cycle of each exit condition
  localparam logic [7:0] MIN_LAST = 8'(MIN_WAIT - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state_r;
  logic [7:0] wait_cnt_r;
  logic       write_r;

  // Cycle sequencer. Each output is loaded with the value that belongs to
  // the state being entered, so outputs track the registered state exactly.
  // latch_addr doubles as the captured request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= S_IDLE;
      wait_cnt_r      <= 8'd0;
      write_r         <= 1'b0;
      req_ready       <= 1'b0;
      latch_addr      <= {ADDR_WIDTH{1'b0}};
      addr_valid      <= 1'b0;
      mem_cycle_start <= 1'b0;
      mem_cycle_end   <= 1'b0;
      mem_oe          <= 1'b0;
      mem_we          <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
      xfer_count      <= 8'd0;
    end else begin
      // Pulse outputs last a single cycle unless re-asserted below
      mem_cycle_start <= 1'b0;
      mem_cycle_end   <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;

      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            latch_addr <= req_addr;
            write_r    <= req_write;
            addr_valid <= 1'b1;
            req_ready  <= 1'b0;
            state_r    <= S_SETUP;
          end else begin
            // Also raises req_ready on the first edge after reset release
            req_ready  <= 1'b1;
            state_r    <= S_IDLE;
          end
        end

        S_SETUP: begin
          mem_cycle_start <= 1'b1;
          state_r         <= S_START;
        end

        S_START: begin
          wait_cnt_r <= 8'd0;
          mem_oe     <= ~write_r;
          mem_we     <= write_r;
          state_r    <= S_ACCESS;
        end

        S_ACCESS: begin
          wait_cnt_r <= wait_cnt_r + 8'd1;
          // Success is tested first so it wins on the timeout edge
          if ((wait_cnt_r >= MIN_LAST) && mem_ready) begin
            mem_oe        <= 1'b0;
            mem_we        <= 1'b0;
            mem_cycle_end <= 1'b1;
            done          <= 1'b1;
            xfer_count    <= xfer_count + 8'd1;
            state_r       <= S_END;
          end else if (wait_cnt_r == TO_LAST) begin
            mem_oe        <= 1'b0;
            mem_we        <= 1'b0;
            mem_cycle_end <= 1'b1;
            timeout_err   <= 1'b1;
            state_r       <= S_END;
          end else begin
            state_r       <= S_ACCESS;
          end
        end

        S_END: begin
          addr_valid <= 1'b0;
          state_r    <= S_RECOVER;
        end

        S_RECOVER: begin
          req_ready <= 1'b1;
          state_r   <= S_IDLE;
        end

        default: begin
          // Unreachable encodings recover to a quiet IDLE
          req_ready  <= 1'b0;
          addr_valid <= 1'b0;
          mem_oe     <= 1'b0;
          mem_we     <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Self-checking bench for mem_cycle_ctrl (default parameters).
// Each transaction is described by the ACCESS-cycle index k from which
// mem_ready is held high. From k alone, the bench derives the ACCESS length
// and the outcome, and from those it builds the full per-cycle output trace.
module tb_mem_cycle_ctrl;

  localparam int AW = 16;
  localparam int MW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] latch_addr;
  logic          addr_valid;
  logic          mem_cycle_start;
  logic          mem_cycle_end;
  logic          mem_oe;
  logic          mem_we;
  logic          done;
  logic          timeout_err;
  logic [7:0]    xfer_count;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;

  mem_cycle_ctrl #(.ADDR_WIDTH(AW), .MIN_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .mem_ready(mem_ready),
    .latch_addr(latch_addr), .addr_valid(addr_valid),
    .mem_cycle_start(mem_cycle_start), .mem_cycle_end(mem_cycle_end),
    .mem_oe(mem_oe), .mem_we(mem_we), .done(done),
    .timeout_err(timeout_err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {req_ready, addr_valid, mem_cycle_start, mem_cycle_end,
            mem_oe, mem_we, done, timeout_err};
  endfunction

  // ACCESS length implied by mem_ready going high at access index k
  function automatic int exp_len(input int k);
    if (k <= MW - 1) return MW;
    else if (k <= TO - 1) return k + 1;
    else return TO;
  endfunction

  // One request, starting at a negedge in IDLE with req_ready already 1.
  // It ends at the negedge of the IDLE cycle that follows RECOVER.
  task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input int k,
                        input logic hold_valid, input logic [AW-1:0] junk);
    int len;
    logic succ;
    logic [7:0] e;
    len  = exp_len(k);
    succ = (k <= TO - 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    mem_ready = (-3 >= k);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready got=%b want=1", req_ready);
    end
    @(posedge clk);
    for (int n = 1; n <= len + 5; n++) begin
      @(negedge clk);
      mem_ready = (n - 3 >= k);
      if (n < len + 5) begin
        req_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
        req_addr  = junk;
        req_write = ~wr;
      end else begin
        req_valid = hold_valid;
      end
      if (n == 1)               e = 8'b0100_0000;
      else if (n == 2)          e = 8'b0110_0000;
      else if (n <= len + 2)    e = {4'b0100, ~wr, wr, 2'b00};
      else if (n == len + 3)    e = {4'b0101, 2'b00, succ, ~succ};
      else if (n == len + 4)    e = 8'b0000_0000;
      else                      e = 8'b1000_0000;
      if (n == len + 3 && succ) model_cnt = (model_cnt + 1) % 256;
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL outputs addr=%h k=%0d cyc=%0d got=%b want=%b", addr, k, n, outs(), e);
      end
      total++;
      if (latch_addr !== addr) begin
        bad++;
        $display("FAIL latch_addr cyc=%0d got=%h want=%h", n, latch_addr, addr);
      end
      if (n != len + 3) begin
        total++;
        if (xfer_count !== 8'(model_cnt)) begin
          bad++;
          $display("FAIL xfer_count cyc=%0d got=%0d want=%0d", n, xfer_count, model_cnt);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (outs() !== 8'h00 || latch_addr !== '0 || xfer_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_vals got=%b/%h/%0d want=0/0/0", outs(), latch_addr, xfer_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_at_release got=%b want=0", req_ready);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_first_cycle got=%b want=1", req_ready);
    end
  endtask

  task automatic test_read();
    do_txn(16'hA000, 1'b0, -3, 1'b0, 16'h5555);
  endtask

  task automatic test_write();
    do_txn(16'hB000, 1'b1, 5, 1'b0, 16'hC000);
  endtask

  task automatic test_timeout();
    do_txn(16'h1234, 1'b0, 99, 1'b0, 16'h4321);
  endtask

  task automatic test_boundary();
    do_txn(16'h0F0F, 1'b1, TO - 1, 1'b0, 16'hF0F0);
    do_txn(16'h0E0E, 1'b0, TO, 1'b0, 16'hE0E0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int k;
      k = int'($urandom_range(0, 23)) - 3;
      do_txn(16'($urandom), 1'($urandom_range(0, 1)), k, 1'b0, 16'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    do_txn(16'h1000, 1'b0, -3, 1'b1, 16'h7777);
    do_txn(16'h1100, 1'b0, -3, 1'b1, 16'h7777);
    do_txn(16'h1200, 1'b0, -3, 1'b0, 16'h7777);
  endtask

  task automatic test_wrap();
    while (model_cnt != 255) do_txn(16'($urandom), 1'($urandom_range(0, 1)), -3, 1'b1, 16'h0);
    do_txn(16'h00FF, 1'b0, -3, 1'b0, 16'h0);
    total++;
    if (xfer_count !== 8'd0) begin
      bad++;
      $display("FAIL wrap got=%0d want=0", xfer_count);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_addr  = 16'h2222;
    req_write = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_cnt = 0;
    total++;
    if (outs() !== 8'h00 || latch_addr !== '0 || xfer_count !== 8'd0) begin
      bad++;
      $display("FAIL async_reset got=%b/%h/%0d want=0/0/0", outs(), latch_addr, xfer_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (outs() !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold got=%b want=00000000", outs());
      end
    end
    rst = 1'b0;
    @(negedge clk);
    do_txn(16'h3333, 1'b0, 4, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_boundary();
    test_random();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
